// File: rtl/bg_layer_scheduler.sv
// Frame-synchronous background scheduler.
// Gates the video timing enable, schedules one background generator per
// frame, advances per-layer horizontal scroll offsets once per frame, and
// optionally rotates through the enabled backgrounds with a blank frame and
// a sticky interrupt at every switch.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata register writes (0 CTRL, 1 DWELL, 2 SPEED, 3 MASK)
//   vsync                    vertical sync, rising edge marks a new frame
//   irq_clr                  one-cycle clear of frame_irq
//   vga_en                   video timing enable
//   bg_en                    one-hot background enable (zero when blanked)
//   cur_bg                   index of the scheduled background
//   scroll_x                 flattened scroll offsets, layer k at [k*SCROLL_W +: SCROLL_W]
//   frame_irq                sticky rotation interrupt
//   state                    FSM state (0 IDLE, 1 ARM, 2 RUN, 3 SWITCH)
module bg_layer_scheduler #(
  parameter int unsigned NUM_BG   = 3,
  parameter int unsigned SCROLL_W = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_addr,
  input  logic [15:0]                cfg_wdata,
  input  logic                       vsync,
  input  logic                       irq_clr,
  output logic                       vga_en,
  output logic [NUM_BG-1:0]          bg_en,
  output logic [1:0]                 cur_bg,
  output logic [NUM_BG*SCROLL_W-1:0] scroll_x,
  output logic                       frame_irq,
  output logic [1:0]                 state
);

  localparam int unsigned SCR_W = NUM_BG * SCROLL_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_SWITCH = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          ctrl_q;
  logic [7:0]          dwell_q;
  logic [15:0]         speed_q;
  logic [NUM_BG-1:0]   mask_q;
  logic                vsync_d_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          cur_bg_q, cur_bg_d;
  logic [SCR_W-1:0]    scroll_q, scroll_d;
  logic                irq_q, irq_d;
  logic                vga_en_q, vga_en_d;
  logic [NUM_BG-1:0]   bg_en_q, bg_en_d;

  logic                frame_tick;
  logic                enable;
  logic                auto_rot;
  logic [3:0]          mask4;
  logic [1:0]          start_pick;
  logic [1:0]          next_pick;
  logic [SCR_W-1:0]    scroll_adv;
  logic [7:0]          cnt_inc;
  logic                rotate;
  logic                unused_speed_c;

  // Every consumer of DWELL/SPEED/MASK samples them only on frame_tick (or
  // not at all in IDLE), so the config register value at the tick is the
  // frame's active copy; a same-cycle write lands afterwards.
  assign frame_tick     = vsync & ~vsync_d_q;
  assign enable         = ctrl_q[0];
  assign auto_rot       = ctrl_q[1];
  assign mask4          = 4'(mask_q);
  assign cnt_inc        = cnt_q + 8'd1;
  assign rotate         = ~mask4[cur_bg_q] |
                          (auto_rot & (dwell_q != 8'd0) & (cnt_inc == dwell_q));
  assign unused_speed_c = ^speed_q;

  // Configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      dwell_q <= '0;
      speed_q <= '0;
      mask_q  <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0: ctrl_q  <= cfg_wdata[3:0];
        2'd1: dwell_q <= cfg_wdata[7:0];
        2'd2: speed_q <= cfg_wdata;
        2'd3: mask_q  <= cfg_wdata[NUM_BG-1:0];
        default: ;
      endcase
    end
  end

  // Scroll offsets after one frame of motion, wrapping per layer.
  always_comb begin
    scroll_adv = scroll_q;
    for (int unsigned k = 0; k < NUM_BG; k++) begin
      scroll_adv[k*SCROLL_W +: SCROLL_W] =
        scroll_q[k*SCROLL_W +: SCROLL_W] + SCROLL_W'(speed_q[k*4 +: 4]);
    end
  end

  // First background when arming: start_bg if enabled, else lowest set bit.
  always_comb begin
    start_pick = 2'd0;
    for (int i = int'(NUM_BG) - 1; i >= 0; i--) begin
      if (mask4[2'(i)]) start_pick = 2'(i);
    end
    if ((32'(ctrl_q[3:2]) < NUM_BG) && mask4[ctrl_q[3:2]]) start_pick = ctrl_q[3:2];
  end

  // Next enabled background after cur_bg, circular; stays put if it is alone.
  always_comb begin
    logic [1:0] idx;
    idx       = 2'd0;
    next_pick = cur_bg_q;
    for (int i = int'(NUM_BG) - 1; i >= 1; i--) begin
      idx = 2'((int'(cur_bg_q) + i) % int'(NUM_BG));
      if (mask4[idx]) next_pick = idx;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    logic irq_set;
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_bg_d = cur_bg_q;
    scroll_d = scroll_q;
    irq_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        scroll_d = '0;
        cnt_d    = '0;
        if (enable) state_d = S_ARM;
      end
      S_ARM: begin
        if (frame_tick && (mask_q != '0)) begin
          state_d  = S_RUN;
          cur_bg_d = start_pick;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (frame_tick) begin
          scroll_d = scroll_adv;
          if (rotate) begin
            state_d = S_SWITCH;
            cnt_d   = '0;
            irq_set = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_SWITCH: begin
        if (frame_tick) begin
          scroll_d = scroll_adv;
          if (mask_q == '0) begin
            state_d = S_ARM;
          end else begin
            state_d  = S_RUN;
            cur_bg_d = next_pick;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable overrides any frame activity in the same cycle.
    if ((state_q != S_IDLE) && !enable) begin
      state_d  = S_IDLE;
      scroll_d = '0;
      cnt_d    = '0;
      cur_bg_d = cur_bg_q;
      irq_set  = 1'b0;
    end

    irq_d    = irq_set | (irq_q & ~irq_clr);
    vga_en_d = (state_d != S_IDLE);
    bg_en_d  = (state_d == S_RUN) ? (NUM_BG'(1) << cur_bg_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vsync_d_q <= 1'b0;
      cnt_q     <= '0;
      cur_bg_q  <= '0;
      scroll_q  <= '0;
      irq_q     <= 1'b0;
      vga_en_q  <= 1'b0;
      bg_en_q   <= '0;
    end else begin
      state_q   <= state_d;
      vsync_d_q <= vsync;
      cnt_q     <= cnt_d;
      cur_bg_q  <= cur_bg_d;
      scroll_q  <= scroll_d;
      irq_q     <= irq_d;
      vga_en_q  <= vga_en_d;
      bg_en_q   <= bg_en_d;
    end
  end

  assign vga_en    = vga_en_q;
  assign bg_en     = bg_en_q;
  assign cur_bg    = cur_bg_q;
  assign scroll_x  = scroll_q;
  assign frame_irq = irq_q;
  assign state     = state_q;

endmodule

// File: tb/tb_bg_layer_scheduler.sv
// Self-checking bench for bg_layer_scheduler: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural frame-level model.
module tb_bg_layer_scheduler;

  localparam int unsigned NUM_BG   = 3;
  localparam int unsigned SCROLL_W = 11;
  localparam int unsigned SCR_W    = NUM_BG * SCROLL_W;
  localparam int          SMOD     = 1 << SCROLL_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_addr = 2'd0;
  logic [15:0]       cfg_wdata = 16'd0;
  logic              vsync = 1'b0;
  logic              irq_clr = 1'b0;
  logic              vga_en;
  logic [NUM_BG-1:0] bg_en;
  logic [1:0]        cur_bg;
  logic [SCR_W-1:0]  scroll_x;
  logic              frame_irq;
  logic [1:0]        state;

  always #5 clk = ~clk;

  bg_layer_scheduler #(.NUM_BG(NUM_BG), .SCROLL_W(SCROLL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .vsync(vsync), .irq_clr(irq_clr),
    .vga_en(vga_en), .bg_en(bg_en), .cur_bg(cur_bg), .scroll_x(scroll_x),
    .frame_irq(frame_irq), .state(state)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 armed, 2 showing a background, 3 blank switch frame.
  int m_ctrl, m_dwell, m_speed, m_mask, m_vsd, m_mode, m_cnt, m_cur, m_irq;
  int m_scroll[NUM_BG];

  function automatic int spd(input int k);
    return (m_speed >> (4 * k)) & 15;
  endfunction

  function automatic bit mbit(input int i);
    return ((m_mask >> i) & 1) != 0;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_dwell = 0; m_speed = 0; m_mask = 0; m_vsd = 0;
    m_mode = 0; m_cnt = 0; m_cur = 0; m_irq = 0;
    for (int k = 0; k < NUM_BG; k++) m_scroll[k] = 0;
  endtask

  task automatic advance();
    for (int k = 0; k < NUM_BG; k++) m_scroll[k] = (m_scroll[k] + spd(k)) % SMOD;
  endtask

  task automatic clear_scroll();
    for (int k = 0; k < NUM_BG; k++) m_scroll[k] = 0;
  endtask

  task automatic model_step();
    bit tick;
    bit set_irq;
    int s;
    tick    = vsync && (m_vsd == 0);
    set_irq = 0;
    if (m_mode == 0) begin
      clear_scroll();
      m_cnt = 0;
      if ((m_ctrl & 1) == 1) m_mode = 1;
    end else if ((m_ctrl & 1) == 0) begin
      m_mode = 0;
      clear_scroll();
      m_cnt = 0;
    end else if (tick) begin
      case (m_mode)
        1: if (m_mask != 0) begin
          s = (m_ctrl >> 2) & 3;
          if (s < int'(NUM_BG) && mbit(s)) m_cur = s;
          else begin
            for (int i = 0; i < int'(NUM_BG); i++) if (mbit(i)) begin m_cur = i; break; end
          end
          m_cnt  = 0;
          m_mode = 2;
        end
        2: begin
          advance();
          m_cnt = (m_cnt + 1) % 256;
          if (!mbit(m_cur) || ((((m_ctrl >> 1) & 1) == 1) && m_dwell != 0 && m_cnt == m_dwell)) begin
            m_mode  = 3;
            m_cnt   = 0;
            set_irq = 1;
          end
        end
        default: begin
          advance();
          if (m_mask == 0) m_mode = 1;
          else begin
            for (int d = 1; d <= int'(NUM_BG); d++) begin
              if (mbit((m_cur + d) % int'(NUM_BG))) begin m_cur = (m_cur + d) % int'(NUM_BG); break; end
            end
            m_mode = 2;
          end
        end
      endcase
    end
    if (set_irq) m_irq = 1;
    else if (irq_clr) m_irq = 0;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: m_ctrl  = int'(cfg_wdata) & 15;
        2'd1: m_dwell = int'(cfg_wdata) & 255;
        2'd2: m_speed = int'(cfg_wdata);
        default: m_mask = int'(cfg_wdata) & ((1 << NUM_BG) - 1);
      endcase
    end
    m_vsd = vsync ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic [SCR_W-1:0]  e_scroll;
    logic [NUM_BG-1:0] e_bg;
    logic              e_vga;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_BG; k++) e_scroll[k*SCROLL_W +: SCROLL_W] = SCROLL_W'(m_scroll[k]);
      e_bg  = (m_mode == 2) ? (NUM_BG'(1) << m_cur) : '0;
      e_vga = (m_mode != 0);
      checks++;
      if (state !== 2'(m_mode) || vga_en !== e_vga || bg_en !== e_bg ||
          cur_bg !== 2'(m_cur) || scroll_x !== e_scroll || frame_irq !== 1'(m_irq)) begin
        failures++;
        $display("FAIL model_cycle t=%0t: got state=%0d vga_en=%0b bg_en=%b cur_bg=%0d scroll_x=%h irq=%0b, expected state=%0d vga_en=%0b bg_en=%b cur_bg=%0d scroll_x=%h irq=%0b",
                 $time, state, vga_en, bg_en, cur_bg, scroll_x, frame_irq,
                 m_mode, e_vga, e_bg, m_cur, e_scroll, m_irq);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int k);
    return 64'(scroll_x[k*SCROLL_W +: SCROLL_W]);
  endfunction

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic frame(input int hi, input int lo);
    @(negedge clk);
    vsync = 1'b1;
    repeat (hi) @(negedge clk);
    vsync = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    logic [NUM_BG-1:0] rot_seq [9];
    logic [31:0] r;
    int vcnt, vhi, vlo;
    rot_seq = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_outputs", 64'({vga_en, bg_en, cur_bg, frame_irq}), 64'd0);
    chk("reset_scroll", 64'(scroll_x), 64'd0);
    rst_n = 1'b1;

    // Get into RUN, then assert reset asynchronously mid-frame.
    cfg_write(2'd2, 16'h0123);
    cfg_write(2'd3, 16'h0007);
    cfg_write(2'd0, 16'h0001);
    @(negedge clk);
    frame(2, 2);
    frame(2, 2);
    chk("pre_reset_run", 64'(state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 64'(state), 64'd0);
    chk("async_rst_outs", 64'({vga_en, bg_en, cur_bg, frame_irq}), 64'd0);
    chk("async_rst_scroll", 64'(scroll_x), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable latency and start_bg selection.
    cfg_write(2'd3, 16'h0007);
    cfg_write(2'd0, 16'h0005);
    chk("en_lat_1cyc", 64'(vga_en), 64'd0);
    @(posedge clk); #1;
    chk("en_lat_2cyc", 64'(vga_en), 64'd1);
    frame(2, 2);
    chk("start_bg_en", 64'(bg_en), 64'b010);
    chk("start_bg_cur", 64'(cur_bg), 64'd1);

    // Scroll wrap over 137 frames.
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd1, 16'h0000);
    cfg_write(2'd2, 16'h010F);
    cfg_write(2'd0, 16'h0001);
    @(negedge clk);
    frame(1, 2);
    repeat (137) frame(1, 2);
    chk("scroll_l0_wrap", lane(0), 64'd7);
    chk("scroll_l1_still", lane(1), 64'd0);
    chk("scroll_l2", lane(2), 64'd137);

    // Auto-rotate with DWELL=3 across mask 101, including the irq race.
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd1, 16'h0003);
    cfg_write(2'd3, 16'h0005);
    cfg_write(2'd0, 16'h0003);
    @(negedge clk);
    for (int f = 0; f < 9; f++) begin
      if (f == 7) begin
        @(negedge clk);
        vsync = 1'b1; irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("rot_bg_f7", 64'(bg_en), 64'(rot_seq[f]));
        chk("irq_race_set_wins", 64'(frame_irq), 64'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_clear", 64'(frame_irq), 64'd0);
        repeat (3) @(negedge clk);
        chk("vsync_held_one_tick", 64'(state), 64'd3);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        frame(2, 2);
        chk($sformatf("rot_bg_f%0d", f), 64'(bg_en), 64'(rot_seq[f]));
        if (f == 3) begin
          chk("rot_irq_f3", 64'(frame_irq), 64'd1);
          irq_clr = 1'b1;
          @(negedge clk);
          irq_clr = 1'b0;
        end
      end
    end
    frame(2, 2);
    frame(2, 2);
    frame(2, 2);
    chk("rot_switch_again", 64'(state), 64'd3);
    chk("rot_irq_again", 64'(frame_irq), 64'd1);

    // Disable during SWITCH, then re-arm with an empty mask.
    cfg_write(2'd0, 16'h0000);
    @(negedge clk);
    chk("dis_state", 64'(state), 64'd0);
    chk("dis_vga", 64'(vga_en), 64'd0);
    chk("dis_scroll", 64'(scroll_x), 64'd0);
    chk("dis_irq_kept", 64'(frame_irq), 64'd1);
    cfg_write(2'd3, 16'h0000);
    cfg_write(2'd0, 16'h0001);
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      frame(2, 2);
      chk($sformatf("arm_hold_f%0d", f), 64'({state, bg_en, vga_en}), 64'({2'd1, 3'b000, 1'b1}));
    end

    // Mask removal of the scheduled background.
    cfg_write(2'd3, 16'h0003);
    cfg_write(2'd0, 16'h0005);
    frame(2, 2);
    chk("mrem_run_bg", 64'(bg_en), 64'b010);
    frame(2, 3);
    cfg_write(2'd3, 16'h0001);
    repeat (2) @(negedge clk);
    chk("mrem_no_change", 64'(bg_en), 64'b010);
    frame(2, 2);
    chk("mrem_blank", 64'({state, bg_en}), 64'({2'd3, 3'b000}));
    frame(2, 2);
    chk("mrem_next", 64'({bg_en, cur_bg}), 64'({3'b001, 2'd0}));

    // Randomized traffic, checked by the model every cycle.
    vcnt = 0; vhi = 1; vlo = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (vcnt == 0) begin
        vlo = $urandom_range(6, 1);
        vhi = ($urandom_range(15, 0) == 0) ? 20 : $urandom_range(4, 1);
        vcnt = vhi + vlo;
      end
      vsync = (vcnt > vlo);
      vcnt--;
      irq_clr = ($urandom_range(9, 0) == 0);
      cfg_we = 1'b0;
      if ($urandom_range(5, 0) == 0) begin
        r = $urandom;
        cfg_we = 1'b1;
        cfg_addr = r[17:16];
        case (r[17:16])
          2'd0: cfg_wdata = {r[15:1], 1'($urandom_range(7, 0) != 0)};
          2'd1: cfg_wdata = 16'($urandom_range(5, 0));
          default: cfg_wdata = r[15:0];
        endcase
      end
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_we = 1'b0;
      end
    end
    @(negedge clk);
    cfg_we = 1'b0; irq_clr = 1'b0; vsync = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_layer_scheduler.md
# bg_layer_scheduler

Frame-synchronous scheduler for the scrolling-background peripheral. It sits between the register block and the video timing and background generators. It gates the video timing enable, selects exactly one background generator per frame, and advances per-layer horizontal scroll offsets on every frame. It can also rotate automatically through the enabled backgrounds, inserting one blank frame at each switch and raising a sticky interrupt.

## Interface
- NUM_BG, 3: number of background generators, legal range 2..4.
- SCROLL_W, 11: width of each scroll offset, matching the pix_x width.
- clk  in  1  peripheral clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_addr  in  2  register select: 0 CTRL, 1 DWELL, 2 SPEED, 3 MASK.
- cfg_wdata  in  16  write data.
  - CTRL[0] = enable.
  - CTRL[1] = auto_rotate.
  - CTRL[3:2] = start_bg.
  - DWELL[7:0] = frames per background.
  - SPEED[4k+3:4k] = layer k speed, in pixels per frame.
  - MASK[NUM_BG-1:0] = background enable mask.
- vsync  in  1  vertical sync from the video timing block, positive polarity.
- irq_clr  in  1  one-cycle clear of frame_irq.
- vga_en  out  1  enable for the video timing block.
- bg_en  out  NUM_BG  one-hot (or zero) background enables.
- cur_bg  out  2  index of the scheduled background.
- scroll_x  out  NUM_BG*SCROLL_W  flattened offsets; layer k occupies bits [k*SCROLL_W +: SCROLL_W].
- frame_irq  out  1  sticky rotation interrupt.
- state  out  2  FSM state: 0 IDLE, 1 ARM, 2 RUN, 3 SWITCH.

## Operation
- **Reset values:** all outputs are 0, all config registers are 0, all active copies are 0, state is IDLE.
- **Config path:**
  - Writes land in config registers at any time.
  - Active copies of DWELL, SPEED and MASK load from the config registers on every frame_tick in ARM, RUN and SWITCH.
  - In IDLE, active copies track the config registers every cycle.
  - If a write and a frame_tick occur in the same cycle, the active copy takes the pre-write value; the new value applies at the next tick.
- **frame_tick:** asserted when vsync is high and its registered copy vsync_d is low.
- **IDLE:** vga_en=0, bg_en=0, scroll offsets held at 0. CTRL.enable=1 moves to ARM.
- **ARM:** vga_en=1, bg_en=0. On frame_tick:
  - if the loaded mask is 0, stay in ARM;
  - otherwise go to RUN with cur_bg = start_bg when that mask bit is set, else the lowest set mask bit. The frame counter is cleared.
- **RUN:** vga_en=1, bg_en=onehot(cur_bg). On frame_tick:
  - every layer k updates scroll_x[k] += speed[k], modulo 2^SCROLL_W (wraps; no saturation);
  - the frame counter increments.
  - Go to SWITCH if either condition holds:
    - the newly loaded mask bit for cur_bg is 0, or
    - auto_rotate=1, DWELL≠0 and the incremented count equals DWELL.
  - DWELL=0 means never rotate.
- **Entering SWITCH:** the frame counter clears and frame_irq sets. A mask-forced switch also sets frame_irq.
- **SWITCH:** vga_en=1, bg_en=0 for one whole frame; scroll offsets keep advancing. On the next frame_tick:
  - cur_bg becomes the next set mask bit after cur_bg, searching circularly;
  - if cur_bg is the only set bit, cur_bg is unchanged;
  - go to RUN;
  - if the mask is now 0, go to ARM instead.
- **Leaving any state:** CTRL.enable=0 in ARM, RUN or SWITCH goes to IDLE on the next edge. Scroll offsets and the frame counter clear. frame_irq keeps its value.
- **frame_irq:**
  - set on SWITCH entry, cleared by irq_clr;
  - if set and clear occur in the same cycle, set wins;
  - not affected by enable.
- Mask bits at or above NUM_BG are ignored. A start_bg value of NUM_BG or more is treated as unset.

## Timing
- All outputs are registered.
- Suppose vsync is first sampled high at cycle t. Then frame_tick is high during t, and the state, bg_en, cur_bg, scroll_x and frame_irq updates are visible at t+1.
- Latency from a CTRL write with enable=1 to vga_en=1 is 2 cycles: the config register updates first, then the FSM.
- Latency from a write clearing enable to vga_en=0 is 2 cycles.
- Outputs change only on frame_tick, except for the enable transitions above.
- Reset mid-frame forces every output to 0 immediately (asynchronous assert). Release is synchronous, and the block restarts in IDLE.
- A vsync held high for many cycles gives exactly one frame_tick.

## Test plan
- **Reset and enable:** assert rst_n low mid-RUN → all outputs 0 with no clock edge. Then write MASK=3'b111, start_bg=1, then enable → vga_en=1 two cycles later; first vsync rise → bg_en=3'b010, cur_bg=1.
- **Scroll wrap:** SPEED layer0=15, layer2=1, starting from 0, run 137 frames → scroll_x[0]=2055 mod 2048=7, scroll_x[2]=137.
- **Auto-rotate:** DWELL=3, auto_rotate=1, MASK=3'b101, start 0 → bg_en sequence per frame: 001, 001, 001, 000, 100, 100, 100, 000, 001. frame_irq sets on each 000 frame.
- **Mask removal:** MASK=3'b011, cur_bg=1. Write MASK=3'b001 mid-frame → no change until the next vsync rise, then one blank frame, then bg_en=001.
- **IRQ race:** frame_irq set/clear collision: assert irq_clr on the same cycle as SWITCH entry → frame_irq=1. irq_clr one cycle later → frame_irq=0.
- **Disable and re-arm:** write enable=0 during SWITCH → IDLE, vga_en=0, scroll_x all 0, frame_irq unchanged. Re-enable with MASK=0 → stays in ARM, bg_en=0, across 3 frames.
